// File: rtl/bus_burst_reader_pkg.sv
// bus_burst_reader_pkg: FSM state type, bus constants and burst-length helper
// shared by bus_burst_reader and its FIFO.
package bus_burst_reader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQUEST,
        S_BEGIN,
        S_DATA,
        S_ABORT,
        S_DONE
    } state_t;

    localparam logic [3:0] BYTE_EN_ALL  = 4'hF;
    localparam int         BURST_SIZE_W = 8;
    localparam int         WORD_BYTES   = 4;

    function automatic logic [8:0] burst_len(input logic [15:0] remaining, input int max_burst);
        return (32'(remaining) > 32'(max_burst)) ? 9'(max_burst) : remaining[8:0];
    endfunction

endpackage

// File: rtl/bus_burst_reader_fifo.sv
// bus_burst_reader_fifo: synchronous FIFO with occupancy and free-slot counts;
// the head word reads as zero while empty.
module bus_burst_reader_fifo
    import bus_burst_reader_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          i_push,
    input  logic [31:0]   i_data,
    input  logic          i_pop,
    output logic [31:0]   o_data,
    output logic [AW:0]   o_count,
    output logic [AW:0]   o_free
);

    localparam logic [AW:0] FULL = DEPTH[AW:0];

    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign w_pop   = i_pop && (r_count != '0);
    assign w_push  = i_push && ((r_count != FULL) || w_pop);
    assign o_data  = (r_count != '0) ? r_mem[r_rd] : '0;
    assign o_count = r_count;
    assign o_free  = FULL - r_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            r_wr    <= w_push ? r_wr + 1'b1 : r_wr;
            r_rd    <= w_pop ? r_rd + 1'b1 : r_rd;
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end

endmodule

// File: rtl/bus_burst_reader.sv
// bus_burst_reader: burst-read bus master that fills a local FIFO for a valid/pop consumer.
// Define BUS_BURST_READER_TIMEOUT_EN to add a 256-idle-cycle watchdog on the DATA phase.
module bus_burst_reader
    import bus_burst_reader_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_BURST  = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    startIn,
    input  logic [31:0]             startAddressIn,
    input  logic [15:0]             wordCountIn,
    output logic                    busyOut,
    output logic                    doneOut,
    output logic                    errorOut,
    output logic                    fifoValidOut,
    output logic [31:0]             fifoDataOut,
    input  logic                    fifoPopIn,
    output logic                    requestTransactionOut,
    input  logic                    transactionGrantedIn,
    output logic                    beginTransactionOut,
    output logic                    endTransactionOut,
    output logic                    readNotWriteOut,
    output logic [3:0]              byteEnablesOut,
    output logic [BURST_SIZE_W-1:0] burstSizeOut,
    output logic [31:0]             addressDataOut,
    input  logic [31:0]             addressDataIn,
    input  logic                    dataValidIn,
    input  logic                    endTransactionIn,
    input  logic                    busErrorIn
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t                  r_state;
    state_t                  w_next;
    logic [31:0]             r_addr;
    logic [31:0]             r_bus_addr;
    logic [15:0]             r_remaining;
    logic [8:0]              r_len;
    logic [8:0]              r_rcv;
    logic [8:0]              w_len;
    logic [BURST_SIZE_W-1:0] r_burst;
    logic                    r_begin;
    logic                    r_end;
    logic                    r_error;
    logic [CW-1:0]           w_count;
    logic [CW-1:0]           w_free;
    logic                    w_req;
    logic                    w_push;
    logic                    w_full;
    logic                    w_last;
    logic                    w_accept;
    logic                    w_timeout;

    // A burst is only requested when the FIFO can take all of it, so the slave never stalls.
    assign w_len    = burst_len(r_remaining, MAX_BURST);
    assign w_req    = (r_state == S_REQUEST) && (32'(w_free) >= 32'(w_len));
    assign w_accept = startIn && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_push   = (r_state == S_DATA) && dataValidIn && !busErrorIn && (r_rcv < r_len);
    assign w_full   = (r_rcv + 9'(w_push)) == r_len;
    assign w_last   = r_remaining == 16'(r_len);

`ifdef BUS_BURST_READER_TIMEOUT_EN
    logic [7:0] r_wd;

    always_ff @(posedge clock) begin
        if (reset || (r_state != S_DATA) || dataValidIn) r_wd <= '0;
        else r_wd <= r_wd + 8'd1;
    end

    assign w_timeout = (r_state == S_DATA) && (r_wd == 8'hFF) && !dataValidIn && !endTransactionIn;
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: w_next = w_accept ? ((wordCountIn == 16'd0) ? S_DONE : S_REQUEST) : S_IDLE;
            S_REQUEST:      w_next = (w_req && transactionGrantedIn) ? S_BEGIN : S_REQUEST;
            S_BEGIN:        w_next = S_DATA;
            S_DATA:         w_next = (busErrorIn || w_timeout) ? S_ABORT :
                                     !endTransactionIn ? S_DATA :
                                     (!w_full || w_last) ? S_DONE : S_REQUEST;
            S_ABORT:        w_next = S_DONE;
            default:        w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_bus_addr  <= '0;
            r_remaining <= '0;
            r_len       <= '0;
            r_rcv       <= '0;
            r_burst     <= '0;
            r_begin     <= 1'b0;
            r_end       <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_begin    <= w_next == S_BEGIN;
            r_end      <= w_next == S_ABORT;
            r_burst    <= (w_next == S_BEGIN) ? BURST_SIZE_W'(w_len - 9'd1) : '0;
            r_bus_addr <= (w_next == S_BEGIN) ? r_addr : '0;
            if (w_accept) begin
                r_addr      <= startAddressIn & ~32'h3;
                r_remaining <= wordCountIn;
            end else if ((r_state == S_DATA) && (w_next == S_REQUEST)) begin
                r_addr      <= r_addr + 32'(r_len) * WORD_BYTES;
                r_remaining <= r_remaining - 16'(r_len);
            end
            if (w_next == S_BEGIN) begin
                r_len <= w_len;
                r_rcv <= '0;
            end else if (w_push) begin
                r_rcv <= r_rcv + 9'd1;
            end
            // Words beyond the burst length are dropped; a short burst is an error.
            if (w_accept) r_error <= 1'b0;
            else if ((r_state == S_DATA) && ((w_next == S_ABORT) || ((w_next == S_DONE) && !w_full))) r_error <= 1'b1;
        end
    end

    bus_burst_reader_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (addressDataIn),
        .i_pop   (fifoPopIn),
        .o_data  (fifoDataOut),
        .o_count (w_count),
        .o_free  (w_free)
    );

    assign fifoValidOut          = w_count != '0;
    assign busyOut               = (r_state != S_IDLE) && (r_state != S_DONE);
    assign doneOut               = r_state == S_DONE;
    assign errorOut              = r_error;
    assign requestTransactionOut = w_req;
    assign beginTransactionOut   = r_begin;
    assign endTransactionOut     = r_end;
    assign readNotWriteOut       = r_begin;
    assign byteEnablesOut        = r_begin ? BYTE_EN_ALL : 4'h0;
    assign burstSizeOut          = r_burst;
    assign addressDataOut        = r_bus_addr;

endmodule

// File: tb/tb_bus_burst_reader.sv
// tb_bus_burst_reader: directed bench with a queue model of the FIFO, per-cycle output
// checks and literal checks on bursts, done/error and reset.
module tb_bus_burst_reader;

    localparam int DEPTH = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        startIn = 1'b0;
    logic [31:0] startAddressIn = '0;
    logic [15:0] wordCountIn = '0;
    logic        busyOut, doneOut, errorOut, fifoValidOut;
    logic [31:0] fifoDataOut;
    logic        fifoPopIn = 1'b0;
    logic        requestTransactionOut;
    logic        transactionGrantedIn = 1'b0;
    logic        beginTransactionOut, endTransactionOut, readNotWriteOut;
    logic [3:0]  byteEnablesOut;
    logic [7:0]  burstSizeOut;
    logic [31:0] addressDataOut;
    logic [31:0] addressDataIn = '0;
    logic        dataValidIn = 1'b0;
    logic        endTransactionIn = 1'b0;
    logic        busErrorIn = 1'b0;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] q[$];
    logic        exp_err = 1'b0;
    int          m_len = 0;
    logic        m_push = 1'b0;
    logic        pop_en = 1'b0;
    int          n_popped = 0;
    int          n_done = 0;

    always #5 clock = ~clock;

    bus_burst_reader dut (
        .clock                 (clock),
        .reset                 (reset),
        .startIn               (startIn),
        .startAddressIn        (startAddressIn),
        .wordCountIn           (wordCountIn),
        .busyOut               (busyOut),
        .doneOut               (doneOut),
        .errorOut              (errorOut),
        .fifoValidOut          (fifoValidOut),
        .fifoDataOut           (fifoDataOut),
        .fifoPopIn             (fifoPopIn),
        .requestTransactionOut (requestTransactionOut),
        .transactionGrantedIn  (transactionGrantedIn),
        .beginTransactionOut   (beginTransactionOut),
        .endTransactionOut     (endTransactionOut),
        .readNotWriteOut       (readNotWriteOut),
        .byteEnablesOut        (byteEnablesOut),
        .burstSizeOut          (burstSizeOut),
        .addressDataOut        (addressDataOut),
        .addressDataIn         (addressDataIn),
        .dataValidIn           (dataValidIn),
        .endTransactionIn      (endTransactionIn),
        .busErrorIn            (busErrorIn)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock; the model absorbs whatever the bench drove into that edge.
    task automatic tick();
        @(posedge clock);
        if (fifoPopIn && q.size() != 0) begin
            void'(q.pop_front());
            n_popped++;
        end
        if (m_push && dataValidIn) q.push_back(addressDataIn);
        #1;
        if (doneOut) n_done++;
        fifoPopIn = pop_en && (q.size() != 0);
    endtask

    task automatic start(input logic [31:0] a, input int c);
        startAddressIn = a;
        wordCountIn = 16'(c);
        startIn = 1'b1;
        m_len = (c > 16) ? 16 : c;
        tick();
        startIn = 1'b0;
        exp_err = 1'b0;
    endtask

    task automatic grant_burst(input logic [31:0] a, input int len);
        int n = 0;
        while (!requestTransactionOut && n < 200) begin
            tick();
            n++;
        end
        chk("request_seen", 32'(n < 200), 32'(1));
        transactionGrantedIn = 1'b1;
        tick();
        transactionGrantedIn = 1'b0;
        m_len = 0;
        chk("begin_strobe", 32'(beginTransactionOut), 32'(1));
        chk("begin_addr", addressDataOut, a);
        chk("begin_size", 32'(burstSizeOut), 32'(len - 1));
        chk("begin_rnw_be", 32'({readNotWriteOut, byteEnablesOut}), 32'h1F);
        tick();
        chk("begin_one_cycle", 32'(beginTransactionOut), 32'(0));
    endtask

    task automatic send_words(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            dataValidIn = 1'b1;
            addressDataIn = base + 32'(i);
            m_push = 1'b1;
            tick();
        end
        dataValidIn = 1'b0;
        addressDataIn = '0;
        m_push = 1'b0;
    endtask

    task automatic end_burst();
        endTransactionIn = 1'b1;
        tick();
        endTransactionIn = 1'b0;
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            chk("fifo_valid", 32'(fifoValidOut), 32'(q.size() != 0));
            if (q.size() != 0) chk("fifo_head", fifoDataOut, q[0]);
            chk("error_flag", 32'(errorOut), 32'(exp_err));
            if (!beginTransactionOut)
                chk("bus_idle_zero", 32'(|{readNotWriteOut, byteEnablesOut, burstSizeOut, addressDataOut}), 32'(0));
            if (requestTransactionOut)
                chk("request_gate", 32'((m_len != 0) && (DEPTH - q.size() >= m_len)), 32'(1));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timed out");
    end

    initial begin
        repeat (3) tick();
        reset = 1'b0;
        chk("reset_ctl", 32'({busyOut, doneOut, errorOut, fifoValidOut, requestTransactionOut, beginTransactionOut,
                              endTransactionOut, readNotWriteOut, byteEnablesOut, burstSizeOut}), 32'(0));
        chk("reset_addr", addressDataOut, 32'(0));
        chk("reset_data", fifoDataOut, 32'(0));
        tick();

        // 20 words from 0xF0000000: bursts of 16 then 4
        pop_en = 1'b1;
        n_popped = 0;
        n_done = 0;
        start(32'hF000_0000, 20);
        chk("busy_after_start", 32'(busyOut), 32'(1));
        grant_burst(32'hF000_0000, 16);
        send_words(32'hA000_0000, 16);
        end_burst();
        m_len = 4;
        chk("busy_between_bursts", 32'(busyOut), 32'(1));
        grant_burst(32'hF000_0040, 4);
        send_words(32'hA000_0010, 4);
        end_burst();
        chk("done_after_two", 32'(doneOut), 32'(1));
        chk("busy_at_done", 32'(busyOut), 32'(0));
        repeat (20) tick();
        chk("popped_20", 32'(n_popped), 32'(20));
        chk("done_once", 32'(n_done), 32'(1));
        chk("no_error_20", 32'(errorOut), 32'(0));

        // zero count
        n_done = 0;
        start(32'h0000_0100, 0);
        chk("zero_done", 32'(doneOut), 32'(1));
        chk("zero_busy", 32'(busyOut), 32'(0));
        tick();
        chk("zero_done_pulse", 32'(n_done), 32'(1));

        // full FIFO withholds the next request until drained
        pop_en = 1'b0;
        n_popped = 0;
        start(32'h0000_1000, 16);
        grant_burst(32'h0000_1000, 16);
        send_words(32'hB000_0000, 16);
        end_burst();
        chk("fill_done", 32'(doneOut), 32'(1));
        start(32'h0000_2002, 16);
        repeat (10) tick();
        chk("withheld", 32'(requestTransactionOut), 32'(0));
        pop_en = 1'b1;
        begin
            int n = 0;
            while (!requestTransactionOut && n < 100) begin
                tick();
                n++;
            end
        end
        chk("request_after_drain", 32'(n_popped), 32'(16));
        grant_burst(32'h0000_2000, 16);
        send_words(32'hC000_0000, 16);
        end_burst();
        chk("second_done", 32'(doneOut), 32'(1));
        repeat (20) tick();

        // bus error on the second word
        pop_en = 1'b0;
        start(32'h0000_3000, 4);
        grant_burst(32'h0000_3000, 4);
        dataValidIn = 1'b1;
        addressDataIn = 32'hD000_0001;
        m_push = 1'b1;
        tick();
        addressDataIn = 32'hD000_0002;
        busErrorIn = 1'b1;
        m_push = 1'b0;
        tick();
        dataValidIn = 1'b0;
        busErrorIn = 1'b0;
        exp_err = 1'b1;
        chk("abort_end_strobe", 32'(endTransactionOut), 32'(1));
        chk("abort_not_done", 32'(doneOut), 32'(0));
        tick();
        chk("abort_end_cleared", 32'(endTransactionOut), 32'(0));
        chk("abort_done", 32'(doneOut), 32'(1));
        chk("abort_one_word", fifoDataOut, 32'hD000_0001);
        pop_en = 1'b1;
        repeat (3) tick();
        chk("abort_fifo_empty", 32'(fifoValidOut), 32'(0));

        // short burst: end after 3 of 4 words
        start(32'h0000_4000, 4);
        chk("error_cleared", 32'(errorOut), 32'(0));
        grant_burst(32'h0000_4000, 4);
        send_words(32'hE000_0000, 3);
        end_burst();
        exp_err = 1'b1;
        chk("short_done", 32'(doneOut), 32'(1));
        repeat (5) tick();
        chk("short_no_request", 32'(requestTransactionOut), 32'(0));
        chk("short_error", 32'(errorOut), 32'(1));

`ifdef BUS_BURST_READER_TIMEOUT_EN
        start(32'h0000_6000, 2);
        grant_burst(32'h0000_6000, 2);
        begin
            int n = 0;
            while (!endTransactionOut && n < 400) begin
                tick();
                n++;
            end
            chk("timeout_cycles", 32'(n), 32'(256));
        end
        exp_err = 1'b1;
        tick();
        chk("timeout_done", 32'(doneOut), 32'(1));
`endif

        // reset in the middle of a burst
        pop_en = 1'b0;
        start(32'h0000_5000, 8);
        grant_burst(32'h0000_5000, 8);
        send_words(32'h9000_0000, 3);
        reset = 1'b1;
        tick();
        q.delete();
        exp_err = 1'b0;
        m_len = 0;
        reset = 1'b0;
        chk("midreset_ctl", 32'({busyOut, doneOut, errorOut, fifoValidOut, requestTransactionOut, beginTransactionOut,
                                 endTransactionOut, readNotWriteOut, byteEnablesOut, burstSizeOut}), 32'(0));
        chk("midreset_data", fifoDataOut, 32'(0));
        tick();
        chk("midreset_no_end", 32'(endTransactionOut), 32'(0));
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
